tpram_sp_arb: RTL and testbench

Arbiter and sequencer that shares one single-port 64x144 SRAM macro between an independent write requester and a read requester. Both requesters use valid/ready handshakes. The block guarantees at most one SRAM access per cycle and never asserts read and write together. Read data returns through a 3-entry response FIFO with backpressure. It sits between the NPU buffer producers/consumers and the single-port SRAM macro, replacing ad-hoc read-priority muxing.

---
 rtl/tpram_arb_pkg.sv | 13 +
 rtl/tpram_rsp_fifo.sv | 64 ++++++
 rtl/tpram_sp_arb.sv | 131 +++++++++++++
 tb/tb_tpram_sp_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package tpram_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

    localparam int RSP_FIFO_DEPTH = 3;
    localparam int STARVE_CNT_W   = 4;

endpackage

// File: rtl/tpram_rsp_fifo.sv
// Three-entry read-response FIFO; push and pop may coincide at any fill level.
module tpram_rsp_fifo
    import tpram_arb_pkg::*;
#(
    parameter int DATA_W = 144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [RSP_FIFO_DEPTH];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RSP_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A pop frees the slot in the same edge, so a push into a full FIFO is legal then.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'(RSP_FIFO_DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tpram_sp_arb.sv
// Read-priority arbiter sharing one single-port SRAM between a writer and a reader.
// Define TPRAM_ARB_STARVE_EN to force a write after STARVE_MAX lost arbitrations.
module tpram_sp_arb
    import tpram_arb_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 144,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be within 1..15");
    end

    grant_e            grant;
    logic              active_q;
    logic              inflight_q;
    logic [1:0]        fifo_count;
    logic              rd_ok;
    logic              force_wr;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] sram_d_q, sram_d_d;

    // A read is only granted when its response is guaranteed a FIFO slot.
    assign rd_ok = rd_valid &&
                   ((3'(fifo_count) + 3'(inflight_q)) < 3'(RSP_FIFO_DEPTH));

`ifdef TPRAM_ARB_STARVE_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_wr = (starve_cnt_q == STARVE_CNT_W'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!wr_valid || grant == GNT_WR) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != '1) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    // Grants stay off until the first edge after reset release so that no
    // SRAM access is ever issued while the block is held in reset.
    always_comb begin
        grant = GNT_NONE;
        if (active_q) begin
            if (rd_ok && !force_wr) begin
                grant = GNT_RD;
            end else if (wr_valid) begin
                grant = GNT_WR;
            end
        end
    end

    always_comb begin
        sram_a_d = sram_a_q;
        sram_d_d = sram_d_q;
        case (grant)
            GNT_RD: sram_a_d = rd_addr;
            GNT_WR: begin
                sram_a_d = wr_addr;
                sram_d_d = wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            inflight_q <= 1'b0;
            sram_a_q   <= '0;
            sram_d_q   <= '0;
        end else begin
            active_q   <= 1'b1;
            inflight_q <= (grant == GNT_RD);
            sram_a_q   <= sram_a_d;
            sram_d_q   <= sram_d_d;
        end
    end

    assign rd_ready = (grant == GNT_RD);
    assign wr_ready = (grant == GNT_WR);
    assign sram_ceb = (grant == GNT_NONE);
    assign sram_web = (grant != GNT_WR);
    assign sram_a   = sram_a_d;
    assign sram_d   = sram_d_d;

    tpram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (sram_q),
        .pop_i       (rsp_ready),
        .valid_o     (rsp_valid),
        .data_o      (rsp_data),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_tpram_sp_arb.sv
// Bench for tpram_sp_arb: directed steps plus a randomized phase against a memory/queue reference.
module tb_tpram_sp_arb;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 144;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    logic [DATA_W-1:0] sram_mem [64];
    logic [DATA_W-1:0] ref_mem [64];
    logic [DATA_W-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int wr_wait = 0;

    tpram_sp_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // ---------------- clock / SRAM macro model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v = '0;
        for (int i = 0; i < 5; i++) v = {v[DATA_W-33:0], 32'($urandom())};
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    // Reference: a plain memory array updated on write handshakes, and an
    // in-order queue of the values each read handshake must return.
    always @(negedge clk) begin
        if (rst_n) begin
            chk1("one_access", rd_ready && wr_ready, 1'b0);
            chk1("ceb", sram_ceb, !(rd_ready || wr_ready));
            if (wr_ready) begin
                chk1("wr_web", sram_web, 1'b0);
                chki("wr_addr_pin", int'(sram_a), int'(wr_addr));
                chkw("wr_data_pin", sram_d, wr_data);
                ref_mem[wr_addr] = wr_data;
`ifdef TPRAM_ARB_STARVE_EN
                chk1("wr_wait_bound", wr_wait <= STARVE_MAX, 1'b1);
`endif
                wr_wait = 0;
            end else if (wr_valid) begin
                wr_wait++;
            end else begin
                wr_wait = 0;
            end
            if (rd_ready) begin
                chk1("rd_web", sram_web, 1'b1);
                chki("rd_addr_pin", int'(sram_a), int'(rd_addr));
                exp_q.push_back(ref_mem[rd_addr]);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chki("rsp_unexpected", exp_q.size(), 1);
                else chkw("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        wr_wait = 0;
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready && n < 50) begin @(negedge clk); n++; end
        chk1("wr_handshake", wr_ready, 1'b1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        int n = 0;
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clk);
        while (!rd_ready && n < 50) begin @(negedge clk); n++; end
        chk1("rd_handshake", rd_ready, 1'b1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk1("rsp_timeout", rsp_valid, 1'b1);
        chkw(tag, rsp_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic idle_drain(input string tag);
        rd_valid = 1'b0; wr_valid = 1'b0; rsp_ready = 1'b1;
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chki(tag, exp_q.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DATA_W-1:0] a5;
        logic [17:0]       seen, seen_exp;
        int                hs, first_wr;
        logic              rd_after, wr_fired, rd_fired;

        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = rand_word();
            ref_mem[i]  = sram_mem[i];
        end
        a5 = {18{8'hA5}};

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'($urandom_range(0, 1)); rd_valid = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            wr_addr = 6'($urandom_range(0, 63)); rd_addr = 6'($urandom_range(0, 63));
            wr_data = rand_word();
            @(negedge clk);
            chk1("rst_ceb", sram_ceb, 1'b1);
            chk1("rst_web", sram_web, 1'b1);
            chk1("rst_rsp_valid", rsp_valid, 1'b0);
            chk1("rst_rd_ready", rd_ready, 1'b0);
            chk1("rst_wr_ready", wr_ready, 1'b0);
        end
        chki("rst_sram_a", int'(sram_a), 0);
        chkw("rst_sram_d", sram_d, '0);

        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // First grant on first request
        rd_valid = 1'b1; rd_addr = 6'd0;
        @(negedge clk);
        chk1("first_grant", rd_ready, 1'b1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        idle_drain("first_drain");

        // Single write / read with latency
        do_write(6'h3F, a5);
        rd_valid = 1'b1; rd_addr = 6'h3F;
        @(negedge clk);
        chk1("lat_rd_grant", rd_ready, 1'b1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        chk1("lat_cycle1", rsp_valid, 1'b0);
        @(negedge clk);
        chk1("lat_cycle2", rsp_valid, 1'b1);
        chkw("lat_data", rsp_data, a5);
        idle_drain("single_drain");

        // Back-to-back reads 0..15
        for (int a = 0; a < 16; a++) do_write(6'(a), rand_word());
        seen = '0;
        for (int k = 0; k < 18; k++) begin
            rd_valid = (k < 16); rd_addr = 6'(k);
            @(negedge clk);
            if (k < 16) chk1("b2b_rd_ready", rd_ready, 1'b1);
            seen[k] = rsp_valid;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        seen_exp = 18'h3FFFC;
        chkw("b2b_rsp_timing", DATA_W'(seen), DATA_W'(seen_exp));
        idle_drain("b2b_drain");

        // Backpressure
        rsp_ready = 1'b0; hs = 0;
        for (int k = 0; k < 10; k++) begin
            rd_valid = 1'b1; rd_addr = 6'(20 + hs);
            @(negedge clk);
            if (rd_ready) hs++;
            @(posedge clk); #1;
        end
        chki("bp_handshakes", hs, 3);
        @(negedge clk);
        chk1("bp_rd_ready_low", rd_ready, 1'b0);
        chk1("bp_rsp_pending", rsp_valid, 1'b1);
        @(posedge clk); #1;
        idle_drain("bp_drain");

        // Starvation
        rd_valid = 1'b1; rd_addr = 6'h31;
        wr_valid = 1'b1; wr_addr = 6'h30; wr_data = rand_word();
        first_wr = 0; rd_after = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first_wr != 0 && k == first_wr + 1) rd_after = rd_ready;
            if (wr_ready && first_wr == 0) first_wr = k;
            @(posedge clk); #1;
            if (first_wr != 0) wr_valid = 1'b0;
        end
`ifdef TPRAM_ARB_STARVE_EN
        chki("starve_wr_cycle", first_wr, STARVE_MAX + 1);
        chk1("starve_rd_resumes", rd_after, 1'b1);
`else
        chki("starve_no_wr", first_wr, 0);
`endif
        idle_drain("starve_drain");

        // Same-address conflict
        do_write(6'd5, DATA_W'(1));
        idle_drain("conf_pre_drain");
        rd_valid = 1'b1; rd_addr = 6'd5;
        wr_valid = 1'b1; wr_addr = 6'd5; wr_data = DATA_W'(2);
        @(negedge clk);
        chk1("conf_rd_first", rd_ready, 1'b1);
        chk1("conf_wr_waits", wr_ready, 1'b0);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        chk1("conf_wr_second", wr_ready, 1'b1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk1("conf_rsp_valid", rsp_valid, 1'b1);
        chkw("conf_old_data", rsp_data, DATA_W'(1));
        @(posedge clk); #1;
        idle_drain("conf_drain");
        read_expect("conf_new_data", 6'd5, DATA_W'(2));
        idle_drain("conf_post_drain");

        // Reset mid-burst drops pending responses
        rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_valid = 1'b1; rd_addr = 6'(k);
            @(posedge clk); #1;
        end
        rst_n = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Randomized traffic with held-until-accepted requests
        wr_fired = 1'b0; rd_fired = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!wr_valid || wr_fired) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = 6'($urandom_range(0, 7));
                wr_data  = rand_word();
            end
            if (!rd_valid || rd_fired) begin
                rd_valid = 1'($urandom_range(0, 1));
                rd_addr  = 6'($urandom_range(0, 7));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            wr_fired = wr_valid && wr_ready;
            rd_fired = rd_valid && rd_ready;
            @(posedge clk); #1;
        end
        idle_drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
